// File: rtl/clk_div_int.sv
// ---------------------------------------------------------------------------
// clk_div_int
//
// Runtime-configurable integer clock divider that sources a derived clock
// domain. In reset, and whenever no valid divide request is present, the
// reference clock is passed straight through (bypass). This keeps the
// downstream reset synchronizer supplied with edges while RST is low.
//
// Parameters:
//   RATIO_WD     width of the divide ratio; maximum ratio is 2**RATIO_WD-1
//
// Ports:
//   CLK          in   reference clock
//   RST          in   asynchronous active-low reset
//   I_CLK_EN     in   1 = divide enabled, 0 = bypass
//   I_DIV_RATIO  in   requested divide ratio N (ratios 0 and 1 mean bypass)
//   O_DIV_CLK    out  divided clock, or CLK while in bypass
//   O_DIV_STB    out  one-CLK strobe per divided period (CLK_DIV_STB_EN only)
//
// Build option:
//   CLK_DIV_STB_EN  when defined, adds the registered O_DIV_STB output.
//
// Each divided period of N cycles is split into floor(N/2) high cycles,
// followed by N-floor(N/2) low cycles. A new ratio is only picked up at a
// period boundary. Dropping I_CLK_EN returns to bypass at the next edge.
// ---------------------------------------------------------------------------
module clk_div_int #(
  parameter int RATIO_WD = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                I_CLK_EN,
  input  logic [RATIO_WD-1:0] I_DIV_RATIO,
  output logic                O_DIV_CLK
`ifdef CLK_DIV_STB_EN
  ,
  output logic                O_DIV_STB
`endif
);

  typedef enum logic {
    MODE_BYPASS = 1'b0,
    MODE_DIV    = 1'b1
  } mode_e;

  localparam logic [RATIO_WD-1:0] MinRatio = RATIO_WD'(2);
  localparam logic [RATIO_WD-1:0] One      = RATIO_WD'(1);

  mode_e               mode_q, mode_d;
  logic [RATIO_WD-1:0] ratio_q, ratio_d;
  logic [RATIO_WD-1:0] cnt_q, cnt_d;
  logic                div_q, div_d;

  logic                reqValid;
  logic                periodEnd;
  logic [RATIO_WD-1:0] cntInc;
  logic [RATIO_WD-1:0] highCycles;

  assign reqValid   = I_CLK_EN && (I_DIV_RATIO >= MinRatio);
  assign cntInc     = cnt_q + One;
  assign highCycles = ratio_q >> 1;
  // cnt_q never exceeds ratio_q-1 in divide mode, so this compare cannot
  // be fooled by the ratio_q==0 wrap; ratio_q is always >= 2 while dividing.
  assign periodEnd  = (cnt_q == (ratio_q - One));

  // State register. Reset forces bypass so the output follows CLK at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mode_q  <= MODE_BYPASS;
      ratio_q <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      ratio_q <= ratio_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

  // Next-state logic for the mode, the period counter and the divided clock.
  always_comb begin
    mode_d  = mode_q;
    ratio_d = ratio_q;
    cnt_d   = cnt_q;
    div_d   = div_q;

    unique case (mode_q)
      MODE_BYPASS: begin
        cnt_d = '0;
        if (reqValid) begin
          // The first divided high phase begins on this very edge.
          mode_d  = MODE_DIV;
          ratio_d = I_DIV_RATIO;
          div_d   = 1'b1;
        end else begin
          div_d   = 1'b0;
        end
      end

      MODE_DIV: begin
        if (!I_CLK_EN) begin
          // Abandon the period in progress immediately.
          mode_d = MODE_BYPASS;
          cnt_d  = '0;
          div_d  = 1'b0;
        end else if (periodEnd) begin
          cnt_d = '0;
          if (reqValid) begin
            ratio_d = I_DIV_RATIO;
            div_d   = 1'b1;
          end else begin
            mode_d = MODE_BYPASS;
            div_d  = 1'b0;
          end
        end else begin
          cnt_d = cntInc;
          div_d = (cntInc < highCycles);
        end
      end

      default: begin
        mode_d = MODE_BYPASS;
        cnt_d  = '0;
        div_d  = 1'b0;
      end
    endcase
  end

  // The select is registered, but the switch itself is a plain mux. A
  // change of mode may therefore produce a short pulse on the output.
  assign O_DIV_CLK = (mode_q == MODE_DIV) ? div_q : CLK;

`ifdef CLK_DIV_STB_EN
  logic stb_q, stb_d;

  // In divide mode the strobe marks the rising edge of the divided clock.
  // Every divided period ends low, so a rise happens once per period.
  // In bypass, every CLK edge is a divided edge, so the strobe is held high.
  always_comb begin
    stb_d = 1'b1;
    if (mode_d == MODE_DIV) begin
      stb_d = div_d && !div_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stb_q <= 1'b0;
    end else begin
      stb_q <= stb_d;
    end
  end

  assign O_DIV_STB = stb_q;
`endif

endmodule

// File: tb/tb_clk_div_int.sv
// ---------------------------------------------------------------------------
// tb_clk_div_int
//
// Directed bench for clk_div_int. Each table row is one CLK cycle: the
// inputs are driven, and the divided clock is then sampled just after the
// rising edge and again just after the falling edge. In bypass these two
// samples read 1 then 0 (the output is CLK). In divide mode both samples
// read the registered divided level.
// ---------------------------------------------------------------------------
module tb_clk_div_int;

  logic       CLK;
  logic       RST;
  logic       I_CLK_EN;
  logic [7:0] I_DIV_RATIO;
  logic       O_DIV_CLK;
`ifdef CLK_DIV_STB_EN
  logic       O_DIV_STB;
`endif

  int errorCount = 0;
  int checkCount = 0;

  typedef struct {
    logic       en;
    logic [7:0] ratio;
    logic       expHi;
    logic       expLo;
    logic       expStb;
  } vec_t;

  vec_t mainVecs[$];
  vec_t postResetVecs[$];

  clk_div_int #(.RATIO_WD(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .I_CLK_EN    (I_CLK_EN),
    .I_DIV_RATIO (I_DIV_RATIO),
    .O_DIV_CLK   (O_DIV_CLK)
`ifdef CLK_DIV_STB_EN
    ,
    .O_DIV_STB   (O_DIV_STB)
`endif
  );

  // 10-unit reference clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Keeps the run bounded even if the sequencing below goes wrong
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %b, required %b", name, actual, expected);
    end
  endtask

  // Drives one row, then samples the high and low halves of that cycle
  task automatic applyStimulus(input int idx, input string tag, input vec_t v);
    I_CLK_EN    = v.en;
    I_DIV_RATIO = v.ratio;
    @(posedge CLK);
    #1;
    checkOutput($sformatf("%s%0d_hi", tag, idx), O_DIV_CLK, v.expHi);
`ifdef CLK_DIV_STB_EN
    checkOutput($sformatf("%s%0d_stb", tag, idx), O_DIV_STB, v.expStb);
`endif
    @(negedge CLK);
    #1;
    checkOutput($sformatf("%s%0d_lo", tag, idx), O_DIV_CLK, v.expLo);
    #1;
  endtask

  task automatic addMain(input logic en, input logic [7:0] r, input logic hi, input logic lo, input logic stb);
    vec_t v;
    v.en = en; v.ratio = r; v.expHi = hi; v.expLo = lo; v.expStb = stb;
    mainVecs.push_back(v);
  endtask

  task automatic addPost(input logic en, input logic [7:0] r, input logic hi, input logic lo, input logic stb);
    vec_t v;
    v.en = en; v.ratio = r; v.expHi = hi; v.expLo = lo; v.expStb = stb;
    postResetVecs.push_back(v);
  endtask

  initial begin
    // N=4: 2 high / 2 low, strobe on each rise
    addMain(1, 4, 1, 1, 1);
    addMain(1, 4, 1, 1, 0);
    addMain(1, 4, 0, 0, 0);
    addMain(1, 4, 0, 0, 0);
    addMain(1, 4, 1, 1, 1);
    addMain(1, 4, 1, 1, 0);
    addMain(1, 4, 0, 0, 0);
    addMain(1, 4, 0, 0, 0);
    // N=5 taken at the period end: 2 high / 3 low
    addMain(1, 5, 1, 1, 1);
    addMain(1, 5, 1, 1, 0);
    addMain(1, 5, 0, 0, 0);
    addMain(1, 5, 0, 0, 0);
    addMain(1, 5, 0, 0, 0);
    // N=3: 1 high / 2 low
    addMain(1, 3, 1, 1, 1);
    addMain(1, 3, 0, 0, 0);
    addMain(1, 3, 0, 0, 0);
    // Back to N=4, then request N=6 at cnt=1; the old period finishes first
    addMain(1, 4, 1, 1, 1);
    addMain(1, 6, 1, 1, 0);
    addMain(1, 6, 0, 0, 0);
    addMain(1, 6, 0, 0, 0);
    // N=6: 3 high / 3 low
    addMain(1, 6, 1, 1, 1);
    addMain(1, 6, 1, 1, 0);
    addMain(1, 6, 1, 1, 0);
    addMain(1, 6, 0, 0, 0);
    addMain(1, 6, 0, 0, 0);
    addMain(1, 6, 0, 0, 0);
    addMain(1, 6, 1, 1, 1);
    addMain(1, 6, 1, 1, 0);
    // Drop EN mid-period: bypass on the next edge
    addMain(0, 6, 1, 0, 1);
    addMain(0, 6, 1, 0, 1);
    // N=1 is not a valid request
    addMain(1, 1, 1, 0, 1);
    // N=2: 1 high / 1 low
    addMain(1, 2, 1, 1, 1);
    addMain(1, 2, 0, 0, 0);
    addMain(1, 2, 1, 1, 1);
    addMain(1, 2, 0, 0, 0);
    // N=1 at the period end returns to bypass
    addMain(1, 1, 1, 0, 1);
    addMain(1, 1, 1, 0, 1);
    // N=8 (4 high / 4 low); reset is applied after the second high cycle
    addMain(1, 8, 1, 1, 1);
    addMain(1, 8, 1, 1, 0);

    // After release with N=8 the period restarts from cnt=0
    addPost(1, 8, 1, 1, 1);
    addPost(1, 8, 1, 1, 0);
    addPost(1, 8, 1, 1, 0);
    addPost(1, 8, 1, 1, 0);
    addPost(1, 8, 0, 0, 0);
    addPost(1, 8, 0, 0, 0);
    addPost(1, 8, 0, 0, 0);
    addPost(1, 8, 0, 0, 0);
    addPost(1, 8, 1, 1, 1);

    // In reset the output follows CLK, even with a valid request present
    RST         = 1'b0;
    I_CLK_EN    = 1'b1;
    I_DIV_RATIO = 8'd4;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      checkOutput($sformatf("rst%0d_hi", i), O_DIV_CLK, 1'b1);
`ifdef CLK_DIV_STB_EN
      checkOutput($sformatf("rst%0d_stb", i), O_DIV_STB, 1'b0);
`endif
      @(negedge CLK);
      #1;
      checkOutput($sformatf("rst%0d_lo", i), O_DIV_CLK, 1'b0);
    end
    I_CLK_EN    = 1'b0;
    I_DIV_RATIO = 8'd0;
    RST         = 1'b1;
    #1;

    for (int i = 0; i < mainVecs.size(); i++) begin
      applyStimulus(i, "main", mainVecs[i]);
    end

    // CLK is low and the divided clock is high, so an asynchronous reset must
    // pull the output low straight away.
    RST = 1'b0;
    #1;
    checkOutput("midReset_now", O_DIV_CLK, 1'b0);
`ifdef CLK_DIV_STB_EN
    checkOutput("midReset_stb", O_DIV_STB, 1'b0);
`endif
    @(posedge CLK);
    #1;
    checkOutput("midReset_hi", O_DIV_CLK, 1'b1);
    @(negedge CLK);
    #1;
    checkOutput("midReset_lo", O_DIV_CLK, 1'b0);
    RST = 1'b1;
    #1;

    for (int i = 0; i < postResetVecs.size(); i++) begin
      applyStimulus(i, "post", postResetVecs[i]);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
